// File: rtl/hack_screen_scanout.sv
// hack_screen_scanout
// Reads the Hack screen memory one word at a time and turns each 16-bit word
// into a one-pixel-per-transfer stream (valid/ready), LSB first, tagged with
// pixel coordinates and frame/line markers. Read-only towards the screen RAM.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            request continuous frame scan-out (sampled at frame end)
//   mem_address       registered read address to the screen RAM
//   mem_out           combinational read data for mem_address
//   pix_valid/ready   pixel handshake
//   pix_data          pixel value (1 = black)
//   pix_x, pix_y      coordinates of the presented pixel
//   frame_start       presented pixel is (0,0)
//   line_end          presented pixel is the last column of its row
module hack_screen_scanout #(
  parameter int ADD_W         = 13,
  parameter int WORDS_PER_ROW = 32,
  parameter int ROWS          = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [ADD_W-1:0] mem_address,
  input  logic [15:0]      mem_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_data,
  output logic [8:0]       pix_x,
  output logic [7:0]       pix_y,
  output logic             frame_start,
  output logic             line_end
);

  localparam int X_LAST = WORDS_PER_ROW * 16 - 1;
  localparam int Y_LAST = ROWS - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  state_t           state_nxt;

  logic [15:0]      sh;
  logic [4:0]       sh_cnt;
  logic [15:0]      pf;
  logic             pf_full;
  logic [ADD_W-1:0] ptr;
  logic [8:0]       x;
  logic [7:0]       y;

  logic             xfer;
  logic             last_x;
  logic             last_y;
  logic             frame_end;
  logic             fetch;
  logic             sh_empty_nxt;
  logic             sh_load;

  assign last_x    = (x == 9'(X_LAST));
  assign last_y    = (y == 8'(Y_LAST));
  assign xfer      = pix_valid & pix_ready;
  assign frame_end = xfer & last_x & last_y;

  // The prefetch slot only refills when it is empty; one word of slack is
  // enough to keep the shifter gapless since a word lasts 16 cycles.
  assign fetch = (state == RUN) & ~pf_full;

  // The shifter reloads either when already empty or on the edge that
  // transfers its last bit, so consecutive words stream without a bubble.
  assign sh_empty_nxt = (sh_cnt == 5'd0) | (xfer & (sh_cnt == 5'd1));
  assign sh_load      = (state == RUN) & sh_empty_nxt & pf_full;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; enable only matters in IDLE and at the frame-end transfer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (frame_end && !enable) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; markers are decoded from the coordinates and gated by valid
  always_comb begin
    pix_valid   = (state == RUN) && (sh_cnt != 5'd0);
    pix_data    = pix_valid & sh[0];
    frame_start = pix_valid & (x == 9'd0) & (y == 8'd0);
    line_end    = pix_valid & last_x;
  end

  assign mem_address = ptr;
  assign pix_x       = x;
  assign pix_y       = y;

  // Control state: counters, flags and the fetch pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_cnt  <= 5'd0;
      pf_full <= 1'b0;
      ptr     <= '0;
      x       <= 9'd0;
      y       <= 8'd0;
    end else if (state == DRAIN) begin
      sh_cnt  <= 5'd0;
      pf_full <= 1'b0;
      ptr     <= '0;
      x       <= 9'd0;
      y       <= 8'd0;
    end else if (state == IDLE) begin
      if (enable) ptr <= '0;
    end else begin
      if (fetch) begin
        pf_full <= 1'b1;
        ptr     <= ptr + 1'b1;
      end else if (sh_load) begin
        pf_full <= 1'b0;
      end

      if (sh_load) begin
        sh_cnt <= 5'd16;
      end else if (xfer) begin
        sh_cnt <= sh_cnt - 5'd1;
      end

      if (xfer) begin
        if (last_x) begin
          x <= 9'd0;
          y <= last_y ? 8'd0 : y + 8'd1;
        end else begin
          x <= x + 9'd1;
        end
      end
    end
  end

  // Data registers: contents are only meaningful while the matching
  // control flag/counter says so, hence no reset
  always_ff @(posedge clk) begin
    if (fetch) pf <= mem_out;
    if (sh_load) begin
      sh <= pf;
    end else if (xfer) begin
      sh <= {1'b0, sh[15:1]};
    end
  end

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Bench for hack_screen_scanout. A reduced frame (8 rows, 256-word memory)
// keeps full-frame and frame-wrap checks short; row width is unchanged.
module tb_hack_screen_scanout;

  localparam int ADD_W = 8;
  localparam int WPR   = 32;
  localparam int ROWS  = 8;
  localparam int NW    = WPR * ROWS;
  localparam int FRAME = NW * 16;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [ADD_W-1:0] mem_address;
  logic [15:0]      mem_out;
  logic             pix_valid;
  logic             pix_ready;
  logic             pix_data;
  logic [8:0]       pix_x;
  logic [7:0]       pix_y;
  logic             frame_start;
  logic             line_end;

  logic [15:0] mem [NW];
  assign mem_out = mem[mem_address];

  hack_screen_scanout #(.ADD_W(ADD_W), .WORDS_PER_ROW(WPR), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .mem_address(mem_address), .mem_out(mem_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line_end(line_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_data"},  32'(pix_data), 32'd0);
    chk({tag, "_x"},     32'(pix_x), 32'd0);
    chk({tag, "_y"},     32'(pix_y), 32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
    chk({tag, "_le"},    32'(line_end), 32'd0);
    chk({tag, "_addr"},  32'(mem_address), 32'd0);
  endtask

  // outputs packed as {valid, data, x, y, fs, le}
  function automatic logic [20:0] pack_out();
    return {pix_valid, pix_data, pix_x, pix_y, frame_start, line_end};
  endfunction

  function automatic logic model_bit(input int px, input int py);
    logic [15:0] w;
    w = mem[py * WPR + px / 16];
    return w[px % 16];
  endfunction

  typedef struct {
    logic       ready;
    logic       valid;
    logic       data;
    logic [8:0] x;
    logic [7:0] y;
    logic       fs;
    logic       le;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0]  lfsr;
    logic [20:0] snap;
    logic        prev_stall;
    logic [ADD_W-1:0] prev_addr;
    int k, ex, ey, frame, c0, c1, gaps;
    bit found, done, wrap_seen;

    // Start vectors, RAM[0]=0x0005: pixels 1,0,1,0,0,0 with a two-cycle stall on x=1
    tbl[0] = '{1'b1, 1'b1, 1'b1, 9'd0, 8'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 9'd1, 8'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 9'd1, 8'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 9'd1, 8'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 9'd2, 8'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 9'd3, 8'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 9'd4, 8'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 9'd5, 8'd0, 1'b0, 1'b0};

    for (int i = 0; i < NW; i++) mem[i] = 16'h0000;
    rst_n = 1'b0; enable = 1'b0; pix_ready = 1'b0;
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // ---- start latency and first pixels ----
    mem[0] = 16'h0005;
    enable = 1'b1; pix_ready = 1'b1;
    step();  // E0
    chk("start_e0_valid", 32'(pix_valid), 32'd0);
    step();  // E1
    chk("start_e1_valid", 32'(pix_valid), 32'd0);
    chk("start_e1_addr", 32'(mem_address), 32'd1);
    step();  // E2
    for (int i = 0; i < 8; i++) begin
      pix_ready = tbl[i].ready;
      chk($sformatf("vec%0d", i), 32'(pack_out()),
          32'({tbl[i].valid, tbl[i].data, tbl[i].x, tbl[i].y, tbl[i].fs, tbl[i].le}));
      step();
    end

    // ---- asynchronous reset mid-stream ----
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    enable = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_idle", 32'(pix_valid), 32'd0);
    end

    // ---- backpressure over the first 64 pixels ----
    for (int i = 0; i < 4; i++) mem[i] = 16'hA5C3;
    lfsr = 8'hA7; k = 0; prev_stall = 1'b0; snap = '0;
    enable = 1'b1;
    for (int cyc = 0; cyc < 600 && k < 64; cyc++) begin
      if (pix_valid) begin
        if (prev_stall) chk("bp_hold", 32'(pack_out()), 32'(snap));
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        pix_ready = lfsr[0];
        if (pix_ready) begin
          chk($sformatf("bp_px%0d", k), 32'({pix_data, pix_x, pix_y}),
              32'({model_bit(k, 0), 9'(k), 8'd0}));
          k++;
        end
        prev_stall = ~pix_ready;
        snap = pack_out();
      end
      step();
    end
    chk("bp_count", 32'(k), 32'd64);
    enable = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // ---- full frames: row boundary, frame wrap, stop ----
    for (int i = 4; i < NW; i++) mem[i] = 16'(i * 40503 + 7);
    mem[31] = 16'h8000;
    mem[32] = 16'h0001;
    enable = 1'b1; pix_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (pix_valid) found = 1'b1;
    end
    chk("run_start", 32'(found), 32'd1);

    ex = 0; ey = 0; frame = 0; c0 = -1; c1 = -1; gaps = 0;
    done = 1'b0; wrap_seen = 1'b0; prev_addr = mem_address;
    for (int cyc = 0; cyc < 3 * FRAME && !done && found; cyc++) begin
      if (prev_addr == ADD_W'(NW - 1) && mem_address == '0) wrap_seen = 1'b1;
      prev_addr = mem_address;
      if (!pix_valid) begin
        gaps++;
        if (gaps == 1) chk("run_gap", 32'(pix_valid), 32'd1);
        if (gaps > 20) done = 1'b1;
      end else begin
        chk("run_px", 32'(pack_out()),
            32'({1'b1, model_bit(ex, ey), 9'(ex), 8'(ey),
                 (ex == 0 && ey == 0), (ex == 511)}));
        if (ex == 511 && ey == 0)
          chk("row_end", 32'({pix_data, line_end}), 32'b11);
        if (ex == 0 && ey == 1)
          chk("row_start", 32'({pix_data, line_end}), 32'b10);
        if (frame_start) begin
          if (c0 < 0) c0 = cyc;
          else if (c1 < 0) c1 = cyc;
        end
        if (frame == 1 && ex == 100 && ey == 5) enable = 1'b0;
        if (ex == 511) begin
          ex = 0;
          if (ey == ROWS - 1) begin
            ey = 0;
            if (frame == 1) done = 1'b1;
            frame++;
          end else begin
            ey++;
          end
        end else begin
          ex++;
        end
      end
      step();
    end
    chk("frames_done", 32'(frame), 32'd2);
    chk("frame_period", 32'(c1 - c0), 32'(FRAME));
    chk("addr_wrap", 32'(wrap_seen), 32'd1);

    // just past the (511,7) transfer with enable low
    chk("stop_valid0", 32'(pix_valid), 32'd0);
    step();
    chk("stop_valid1", 32'(pix_valid), 32'd0);
    chk("stop_addr", 32'(mem_address), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("stop_idle", 32'({pix_valid, mem_address}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
